// File: rtl/bf_pkg.sv
// bf_pkg: opcode bytes, one-hot op classes and FSM state encodings for bf_core.
package bf_pkg;
  localparam logic [7:0] OP_INC_P = 8'h3E;
  localparam logic [7:0] OP_DEC_P = 8'h3C;
  localparam logic [7:0] OP_INC_C = 8'h2B;
  localparam logic [7:0] OP_DEC_C = 8'h2D;
  localparam logic [7:0] OP_PUT   = 8'h2E;
  localparam logic [7:0] OP_GET   = 8'h2C;
  localparam logic [7:0] OP_JZ    = 8'h5B;
  localparam logic [7:0] OP_JNZ   = 8'h5D;
  localparam logic [7:0] OP_HALT  = 8'h00;
  typedef struct packed {
    logic inc_p;
    logic dec_p;
    logic inc_c;
    logic dec_c;
    logic put;
    logic get;
    logic jz;
    logic jnz;
    logic halt;
    logic nop;
  } op_t;
  typedef logic [2:0] state_t;
  localparam state_t S_RESET    = 3'd0;
  localparam state_t S_FETCH    = 3'd1;
  localparam state_t S_EXEC     = 3'd2;
  localparam state_t S_WRITE    = 3'd3;
  localparam state_t S_SCAN     = 3'd4;
  localparam state_t S_WAIT_IN  = 3'd5;
  localparam state_t S_WAIT_OUT = 3'd6;
  localparam state_t S_HALT     = 3'd7;
endpackage

// File: rtl/bf_if.sv
// bf_if: program/data memory buses, input/output streams and halt flag of bf_core.
interface bf_if #(
  parameter int PROG_AW = 8,
  parameter int DATA_AW = 8,
  parameter int CELL_W  = 8
);
  logic [PROG_AW-1:0] prog_addr;
  logic               prog_ren;
  logic [7:0]         prog_rval;
  logic [DATA_AW-1:0] data_addr;
  logic               data_ren;
  logic               data_wen;
  logic [CELL_W-1:0]  data_wval;
  logic [CELL_W-1:0]  data_rval;
  logic               in_valid;
  logic               in_ready;
  logic [CELL_W-1:0]  in_data;
  logic               out_valid;
  logic               out_ready;
  logic [CELL_W-1:0]  out_data;
  logic               halted;
  modport master (
    output prog_addr, prog_ren, data_addr, data_ren, data_wen, data_wval,
    output in_ready, out_valid, out_data, halted,
    input  prog_rval, data_rval, in_valid, in_data, out_ready
  );
  modport slave (
    input  prog_addr, prog_ren, data_addr, data_ren, data_wen, data_wval,
    input  in_ready, out_valid, out_data, halted,
    output prog_rval, data_rval, in_valid, in_data, out_ready
  );
endinterface

// File: rtl/bf_decode.sv
// bf_decode: classifies an opcode byte into exactly one op class (unknown bytes are nop).
module bf_decode
  import bf_pkg::*;
(
  input  logic [7:0] opcode,
  output op_t        op
);
  always_comb begin
    op       = '0;
    op.inc_p = opcode == OP_INC_P;
    op.dec_p = opcode == OP_DEC_P;
    op.inc_c = opcode == OP_INC_C;
    op.dec_c = opcode == OP_DEC_C;
    op.put   = opcode == OP_PUT;
    op.get   = opcode == OP_GET;
    op.jz    = opcode == OP_JZ;
    op.jnz   = opcode == OP_JNZ;
    op.halt  = opcode == OP_HALT;
    op.nop   = op == '0;
  end
endmodule

// File: rtl/bf_core.sv
// bf_core: Brainfuck execution core with bracket scanning, stream handshakes and halt.
module bf_core
  import bf_pkg::*;
#(
  parameter int PROG_AW = 8,
  parameter int DATA_AW = 8,
  parameter int CELL_W  = 8,
  parameter int NEST_W  = 8
) (
  input logic clk,
  input logic reset,
  bf_if.master bus
);
  state_t             state_q, state_d;
  logic [PROG_AW-1:0] pc_q, pc_d;
  logic [DATA_AW-1:0] dp_q, dp_d;
  logic [CELL_W-1:0]  wval_q, wval_d, out_data_q, out_data_d;
  logic [NEST_W-1:0]  depth_q, depth_d;
  logic prog_ren_q, prog_ren_d, data_ren_q, data_ren_d, data_wen_q, data_wen_d;
  logic in_ready_q, in_ready_d, out_valid_q, out_valid_d, halted_q, halted_d;
  logic fwd_q, fwd_d, rd_q, rd_d;
  logic step, wrap, deeper, closer, cell_nz;
  op_t  op;
  bf_decode u_dec (.opcode(bus.prog_rval), .op(op));
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    dp_d        = dp_q;
    wval_d      = wval_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    depth_d     = depth_q;
    fwd_d       = fwd_q;
    rd_d        = 1'b0;
    step        = 1'b0;
    cell_nz     = |bus.data_rval;
    deeper      = fwd_q ? op.jz : op.jnz;
    closer      = fwd_q ? op.jnz : op.jz;
    case (state_q)
      S_RESET: state_d = S_FETCH;
      S_FETCH: state_d = S_EXEC;
      S_EXEC: begin
        state_d     = (op.inc_c | op.dec_c) ? S_WRITE :
                      op.put ? S_WAIT_OUT : op.get ? S_WAIT_IN : op.halt ? S_HALT : S_FETCH;
        pc_d        = (op.nop | op.inc_p | op.dec_p | op.jz | op.jnz) ? pc_q + 1'b1 : pc_q;
        dp_d        = op.inc_p ? dp_q + 1'b1 : op.dec_p ? dp_q - 1'b1 : dp_q;
        wval_d      = op.inc_c ? bus.data_rval + 1'b1 : op.dec_c ? bus.data_rval - 1'b1 : wval_q;
        out_valid_d = op.put;
        out_data_d  = op.put ? bus.data_rval : out_data_q;
        in_ready_d  = op.get;
        if ((op.jz && !cell_nz) || (op.jnz && cell_nz)) begin
          depth_d = NEST_W'(1);
          fwd_d   = op.jz;
          step    = 1'b1;
        end
      end
      S_WRITE: begin
        state_d = S_FETCH;
        pc_d    = pc_q + 1'b1;
      end
      S_WAIT_OUT: if (bus.out_ready) begin
        out_valid_d = 1'b0;
        pc_d        = pc_q + 1'b1;
        state_d     = S_FETCH;
      end
      S_WAIT_IN: if (bus.in_valid) begin
        wval_d     = bus.in_data;
        in_ready_d = 1'b0;
        state_d    = S_WRITE;
      end
      // rd_q marks the read half of a scan step; the opcode is compared on the following cycle
      S_SCAN: if (!rd_q) begin
        if (deeper && &depth_q) state_d = S_HALT;
        else if (closer && depth_q == NEST_W'(1)) begin
          depth_d = '0;
          pc_d    = pc_q + 1'b1;
          state_d = S_FETCH;
        end else begin
          depth_d = deeper ? depth_q + 1'b1 : closer ? depth_q - 1'b1 : depth_q;
          step    = 1'b1;
        end
      end
      default: ;
    endcase
    wrap = fwd_d ? &pc_q : pc_q == '0;
    if (step) begin
      state_d = wrap ? S_HALT : S_SCAN;
      pc_d    = wrap ? pc_q : fwd_d ? pc_q + 1'b1 : pc_q - 1'b1;
      rd_d    = !wrap;
    end
    prog_ren_d = state_d == S_FETCH || (state_d == S_SCAN && rd_d);
    data_ren_d = state_d == S_FETCH;
    data_wen_d = state_d == S_WRITE;
    halted_d   = halted_q || state_d == S_HALT;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= S_RESET;
      pc_q        <= '0;
      dp_q        <= '0;
      wval_q      <= '0;
      out_data_q  <= '0;
      depth_q     <= '0;
      prog_ren_q  <= 1'b0;
      data_ren_q  <= 1'b0;
      data_wen_q  <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      halted_q    <= 1'b0;
      fwd_q       <= 1'b0;
      rd_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      dp_q        <= dp_d;
      wval_q      <= wval_d;
      out_data_q  <= out_data_d;
      depth_q     <= depth_d;
      prog_ren_q  <= prog_ren_d;
      data_ren_q  <= data_ren_d;
      data_wen_q  <= data_wen_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      halted_q    <= halted_d;
      fwd_q       <= fwd_d;
      rd_q        <= rd_d;
    end
  end
  assign bus.prog_addr = pc_q;
  assign bus.prog_ren  = prog_ren_q;
  assign bus.data_addr = dp_q;
  assign bus.data_ren  = data_ren_q;
  assign bus.data_wen  = data_wen_q;
  assign bus.data_wval = wval_q;
  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.halted    = halted_q;
endmodule

// File: tb/tb_bf_core.sv
// tb_bf_core: scoreboard bench for bf_core with 8-bit and 16-bit cell instances.
module tb_bf_core;
  typedef struct packed {
    logic [7:0]  addr;
    logic [15:0] data;
  } beat_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  bf_if #(.PROG_AW(8), .DATA_AW(8), .CELL_W(8))  b8 ();
  bf_if #(.PROG_AW(8), .DATA_AW(8), .CELL_W(16)) b16 ();
  bf_core #(.PROG_AW(8), .DATA_AW(8), .CELL_W(8), .NEST_W(8)) dut (
    .clk(clk), .reset(rst_n), .bus(b8.master)
  );
  bf_core #(.PROG_AW(8), .DATA_AW(8), .CELL_W(16), .NEST_W(8)) dut16 (
    .clk(clk), .reset(rst_n), .bus(b16.master)
  );
  logic [7:0]  prog8 [256];
  logic [7:0]  prog16 [256];
  logic [7:0]  dmem8 [256];
  logic [15:0] dmem16 [256];
  beat_t exp8[$];
  beat_t exp16[$];
  int n_cmp = 0;
  int n_bad = 0;
  int beats8 = 0;
  int beats16 = 0;
  always @(posedge clk) begin
    if (b8.prog_ren) b8.prog_rval <= prog8[b8.prog_addr];
    if (b8.data_wen) dmem8[b8.data_addr] <= b8.data_wval;
    if (b8.data_ren) b8.data_rval <= dmem8[b8.data_addr];
    if (b16.prog_ren) b16.prog_rval <= prog16[b16.prog_addr];
    if (b16.data_wen) dmem16[b16.data_addr] <= b16.data_wval;
    if (b16.data_ren) b16.data_rval <= dmem16[b16.data_addr];
  end
  always @(negedge clk) begin
    beat_t e;
    if (rst_n === 1'b1 && b8.out_valid === 1'b1 && b8.out_ready === 1'b1) begin
      beats8++;
      n_cmp++;
      if (exp8.size() == 0) begin
        n_bad++;
        $display("FAIL beat8_unexpected: got data=%h addr=%h, none expected", b8.out_data, b8.data_addr);
      end else begin
        e = exp8.pop_front();
        if ({b8.data_addr, 8'h00, b8.out_data} !== {e.addr, e.data}) begin
          n_bad++;
          $display("FAIL beat8: got addr=%h data=%h want addr=%h data=%h", b8.data_addr, b8.out_data, e.addr, e.data);
        end
      end
    end
    if (rst_n === 1'b1 && b16.out_valid === 1'b1 && b16.out_ready === 1'b1) begin
      beats16++;
      n_cmp++;
      if (exp16.size() == 0) begin
        n_bad++;
        $display("FAIL beat16_unexpected: got data=%h addr=%h, none expected", b16.out_data, b16.data_addr);
      end else begin
        e = exp16.pop_front();
        if ({b16.data_addr, b16.out_data} !== {e.addr, e.data}) begin
          n_bad++;
          $display("FAIL beat16: got addr=%h data=%h want addr=%h data=%h", b16.data_addr, b16.out_data, e.addr, e.data);
        end
      end
    end
  end
  task automatic load8(input string s);
    for (int i = 0; i < 256; i++) begin
      prog8[i] = 8'h00;
      dmem8[i] = 8'h00;
    end
    for (int i = 0; i < s.len(); i++) prog8[i] = s[i];
  endtask
  task automatic start();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask
  task automatic wait_halt8(input int budget, output int n);
    n = 0;
    while (b8.halted !== 1'b1 && n < budget) begin
      @(posedge clk);
      #1 n++;
    end
  endtask
  task automatic test_reset();
    load8("+");
    b8.out_ready = 1'b1;
    b8.in_valid  = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (b8.prog_addr !== 8'h00) begin n_bad++; $display("FAIL reset_prog_addr: got %h want 00", b8.prog_addr); end
    n_cmp++;
    if (b8.data_addr !== 8'h00) begin n_bad++; $display("FAIL reset_data_addr: got %h want 00", b8.data_addr); end
    n_cmp++;
    if ({b8.prog_ren, b8.data_ren, b8.data_wen} !== 3'b000) begin
      n_bad++; $display("FAIL reset_enables: got %b want 000", {b8.prog_ren, b8.data_ren, b8.data_wen});
    end
    n_cmp++;
    if ({b8.in_ready, b8.out_valid, b8.halted} !== 3'b000) begin
      n_bad++; $display("FAIL reset_flags: got %b want 000", {b8.in_ready, b8.out_valid, b8.halted});
    end
    n_cmp++;
    if ({b8.data_wval, b8.out_data} !== 16'h0000) begin
      n_bad++; $display("FAIL reset_values: got %h want 0000", {b8.data_wval, b8.out_data});
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    n_cmp++;
    if ({b8.prog_ren, b8.data_ren, b8.data_wen} !== 3'b110) begin
      n_bad++; $display("FAIL first_fetch: got %b want 110", {b8.prog_ren, b8.data_ren, b8.data_wen});
    end
  endtask
  task automatic test_add_out();
    int n;
    load8("+++.");
    b8.out_ready = 1'b1;
    exp8.push_back({8'h00, 16'h0003});
    start();
    wait_halt8(60, n);
    n_cmp++;
    if (n !== 15) begin n_bad++; $display("FAIL add_halt_latency: got %0d want 15", n); end
    n_cmp++;
    if (exp8.size() != 0) begin n_bad++; $display("FAIL add_beats_missing: got %0d left want 0", exp8.size()); end
    n_cmp++;
    if (b8.prog_addr !== 8'h04) begin n_bad++; $display("FAIL add_halt_pc: got %h want 04", b8.prog_addr); end
    n_cmp++;
    if ({b8.prog_ren, b8.data_ren, b8.data_wen, b8.in_ready, b8.out_valid} !== 5'b0) begin
      n_bad++; $display("FAIL halt_enables: got %b want 00000", {b8.prog_ren, b8.data_ren, b8.data_wen, b8.in_ready, b8.out_valid});
    end
    n_cmp++;
    if (dmem8[0] !== 8'h03) begin n_bad++; $display("FAIL add_cell0: got %h want 03", dmem8[0]); end
  endtask
  task automatic test_loop();
    int n;
    load8("++[->+<]>.");
    exp8.push_back({8'h01, 16'h0002});
    start();
    wait_halt8(400, n);
    n_cmp++;
    if (b8.halted !== 1'b1) begin n_bad++; $display("FAIL loop_halted: got %b want 1", b8.halted); end
    n_cmp++;
    if (exp8.size() != 0) begin n_bad++; $display("FAIL loop_beats_missing: got %0d left want 0", exp8.size()); end
    n_cmp++;
    if ({dmem8[0], dmem8[1]} !== 16'h0002) begin
      n_bad++; $display("FAIL loop_cells: got %h want 0002", {dmem8[0], dmem8[1]});
    end
  endtask
  task automatic test_skip();
    int n;
    load8("[+.]");
    start();
    wait_halt8(100, n);
    n_cmp++;
    if (b8.halted !== 1'b1) begin n_bad++; $display("FAIL skip_halted: got %b want 1", b8.halted); end
    n_cmp++;
    if ({b8.prog_addr, dmem8[0]} !== 16'h0400) begin
      n_bad++; $display("FAIL skip_pc_cell: got %h want 0400", {b8.prog_addr, dmem8[0]});
    end
    load8("[[]]+.");
    exp8.push_back({8'h00, 16'h0001});
    start();
    wait_halt8(100, n);
    n_cmp++;
    if (b8.halted !== 1'b1) begin n_bad++; $display("FAIL nested_halted: got %b want 1", b8.halted); end
    n_cmp++;
    if (exp8.size() != 0) begin n_bad++; $display("FAIL nested_beats_missing: got %0d left want 0", exp8.size()); end
  endtask
  task automatic test_io();
    int n;
    int b0;
    logic ok;
    load8(",+.");
    b8.out_ready = 1'b0;
    b8.in_valid  = 1'b0;
    b8.in_data   = 8'h00;
    exp8.push_back({8'h00, 16'h0042});
    b0 = beats8;
    start();
    n = 0;
    while (b8.in_ready !== 1'b1 && n < 20) begin @(posedge clk); #1 n++; end
    ok = 1'b1;
    repeat (5) begin
      ok &= b8.in_ready === 1'b1;
      @(posedge clk);
      #1;
    end
    n_cmp++;
    if (!ok || b8.in_ready !== 1'b1) begin n_bad++; $display("FAIL in_ready_hold: got %b want 1", b8.in_ready); end
    b8.in_valid = 1'b1;
    b8.in_data  = 8'h41;
    @(posedge clk);
    #1 b8.in_valid = 1'b0;
    n_cmp++;
    if (b8.in_ready !== 1'b0) begin n_bad++; $display("FAIL in_ready_drop: got %b want 0", b8.in_ready); end
    n = 0;
    while (b8.out_valid !== 1'b1 && n < 20) begin @(posedge clk); #1 n++; end
    ok = 1'b1;
    repeat (3) begin
      ok &= b8.out_valid === 1'b1 && b8.out_data === 8'h42;
      @(posedge clk);
      #1;
    end
    n_cmp++;
    if (!ok || b8.out_valid !== 1'b1 || b8.out_data !== 8'h42) begin
      n_bad++; $display("FAIL out_stall_hold: got valid=%b data=%h want valid=1 data=42", b8.out_valid, b8.out_data);
    end
    b8.out_ready = 1'b1;
    wait_halt8(40, n);
    n_cmp++;
    if (b8.halted !== 1'b1 || beats8 - b0 != 1) begin
      n_bad++; $display("FAIL io_beats: got halted=%b beats=%0d want halted=1 beats=1", b8.halted, beats8 - b0);
    end
  endtask
  task automatic test_wrap();
    int n;
    load8("-.<.");
    exp8.push_back({8'h00, 16'h00FF});
    exp8.push_back({8'hFF, 16'h0000});
    start();
    wait_halt8(60, n);
    n_cmp++;
    if (exp8.size() != 0 || b8.halted !== 1'b1) begin
      n_bad++; $display("FAIL wrap8_done: got left=%0d halted=%b want left=0 halted=1", exp8.size(), b8.halted);
    end
    n_cmp++;
    if (b8.data_addr !== 8'hFF) begin n_bad++; $display("FAIL wrap8_dp: got %h want ff", b8.data_addr); end
  endtask
  task automatic test_cell16();
    int n;
    load8("");
    for (int i = 0; i < 256; i++) begin
      prog16[i] = 8'h00;
      dmem16[i] = 16'h0000;
    end
    prog16[0] = 8'h2D;
    prog16[1] = 8'h2E;
    prog16[2] = 8'h3C;
    prog16[3] = 8'h2E;
    exp16.push_back({8'h00, 16'hFFFF});
    exp16.push_back({8'hFF, 16'h0000});
    start();
    n = 0;
    while (b16.halted !== 1'b1 && n < 60) begin @(posedge clk); #1 n++; end
    n_cmp++;
    if (exp16.size() != 0 || b16.halted !== 1'b1) begin
      n_bad++; $display("FAIL wrap16_done: got left=%0d halted=%b want left=0 halted=1", exp16.size(), b16.halted);
    end
    n_cmp++;
    if (dmem16[0] !== 16'hFFFF) begin n_bad++; $display("FAIL wrap16_cell0: got %h want ffff", dmem16[0]); end
    for (int i = 0; i < 4; i++) prog16[i] = 8'h00;
  endtask
  task automatic test_reset_mid();
    int n;
    int b0;
    load8(".");
    b8.out_ready = 1'b0;
    start();
    n = 0;
    while (b8.out_valid !== 1'b1 && n < 20) begin @(posedge clk); #1 n++; end
    n_cmp++;
    if (b8.out_valid !== 1'b1) begin n_bad++; $display("FAIL mid_out_valid: got %b want 1", b8.out_valid); end
    b0 = beats8;
    rst_n = 1'b0;
    b8.out_ready = 1'b1;
    @(posedge clk);
    #1;
    n_cmp++;
    if ({b8.out_valid, b8.prog_addr, b8.halted} !== 10'b0) begin
      n_bad++; $display("FAIL mid_reset: got valid=%b pc=%h halted=%b want 0/00/0", b8.out_valid, b8.prog_addr, b8.halted);
    end
    n_cmp++;
    if (beats8 != b0) begin n_bad++; $display("FAIL mid_no_transfer: got %0d beats want 0", beats8 - b0); end
    exp8.push_back({8'h00, 16'h0000});
    rst_n = 1'b1;
    wait_halt8(40, n);
    n_cmp++;
    if (b8.halted !== 1'b1 || exp8.size() != 0) begin
      n_bad++; $display("FAIL mid_restart: got halted=%b left=%0d want halted=1 left=0", b8.halted, exp8.size());
    end
  endtask
  task automatic test_unmatched();
    int n;
    load8("+]");
    start();
    wait_halt8(60, n);
    n_cmp++;
    if ({b8.halted, b8.prog_addr} !== 9'h100) begin
      n_bad++; $display("FAIL unmatched_close: got halted=%b pc=%h want 1/00", b8.halted, b8.prog_addr);
    end
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    n_cmp++;
    if ({b8.halted, b8.prog_addr} !== 9'h000) begin
      n_bad++; $display("FAIL unmatched_reset: got halted=%b pc=%h want 0/00", b8.halted, b8.prog_addr);
    end
    load8("[");
    start();
    wait_halt8(1000, n);
    n_cmp++;
    if ({b8.halted, b8.prog_addr} !== 9'h1FF) begin
      n_bad++; $display("FAIL unmatched_open: got halted=%b pc=%h want 1/ff", b8.halted, b8.prog_addr);
    end
  endtask
  initial begin
    for (int i = 0; i < 256; i++) begin
      prog16[i] = 8'h00;
      dmem16[i] = 16'h0000;
    end
    b16.in_valid  = 1'b0;
    b16.in_data   = 16'h0000;
    b16.out_ready = 1'b1;
    b8.in_valid   = 1'b0;
    b8.in_data    = 8'h00;
    b8.out_ready  = 1'b1;
    test_reset();
    test_add_out();
    test_loop();
    test_skip();
    test_io();
    b8.out_ready = 1'b1;
    test_wrap();
    test_cell16();
    test_reset_mid();
    test_unmatched();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, compared=%0d", n_cmp);
    $fatal(1, "timeout");
  end
endmodule
